// File: rtl/l2_mem_requester.sv
// L2-to-memory request engine: takes one miss at a time, writes back a dirty
// victim first, then fetches the fill and hands it back to L2 as a pulse.
module l2_mem_requester #(
    parameter int TAG_W   = 18,
    parameter int IDX_W   = 8,
    parameter int BLK_W   = 128,
    parameter int TIMEOUT = 4096
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_dirty,
    input  logic [TAG_W-1:0] req_tag,
    input  logic [IDX_W-1:0] req_index,
    input  logic [TAG_W-1:0] req_victim_tag,
    input  logic [BLK_W-1:0] req_victim_data,
    output logic             resp_valid,
    output logic [BLK_W-1:0] resp_data,
    output logic             read_L2_MEM,
    output logic             write_L2_MEM,
    output logic [TAG_W-1:0] tag_L2_MEM,
    output logic [IDX_W-1:0] index_L2_MEM,
    output logic [TAG_W-1:0] write_tag_L2_MEM,
    output logic [BLK_W-1:0] write_data_L2_MEM,
    input  logic [BLK_W-1:0] read_data_MEM_L2,
    input  logic             ready_MEM_L2,
    output logic             timeout_err
);

    localparam int CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ARM = CNT_W'(TIMEOUT - 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WB,
        S_WB_GAP,
        S_FILL,
        S_RESP
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [TAG_W-1:0]   r_tag;
    logic [IDX_W-1:0]   r_index;
    logic [TAG_W-1:0]   r_victim_tag;
    logic [BLK_W-1:0]   r_victim_data;
    logic [BLK_W-1:0]   r_resp_data;
    logic               r_resp_valid;
    logic               r_read;
    logic               r_write;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_timeout_err;
    logic               w_waiting;
    logic               w_phase_entry;
    logic               w_accept;

    assign w_accept      = (r_state == S_IDLE) && req_valid;
    assign w_waiting     = ((r_state == S_WB) || (r_state == S_FILL)) && !ready_MEM_L2;
    assign w_phase_entry = (w_state_next != r_state) &&
                           ((w_state_next == S_WB) || (w_state_next == S_FILL));

    // RESP spends its first cycle settling resp_data and pulses resp_valid in its second.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:   if (req_valid) w_state_next = req_dirty ? S_WB : S_FILL;
            S_WB:     if (ready_MEM_L2) w_state_next = S_WB_GAP;
            S_WB_GAP: w_state_next = S_FILL;
            S_FILL:   if (ready_MEM_L2) w_state_next = S_RESP;
            S_RESP:   if (r_resp_valid) w_state_next = S_IDLE;
            default:  w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state       <= S_IDLE;
            r_tag         <= '0;
            r_index       <= '0;
            r_victim_tag  <= '0;
            r_victim_data <= '0;
            r_resp_data   <= '0;
            r_resp_valid  <= 1'b0;
            r_read        <= 1'b0;
            r_write       <= 1'b0;
            r_cnt         <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_write      <= (w_state_next == S_WB);
            r_read       <= (w_state_next == S_FILL);
            r_resp_valid <= (r_state == S_RESP) && !r_resp_valid;
            if (w_accept) begin
                r_tag         <= req_tag;
                r_index       <= req_index;
                r_victim_tag  <= req_victim_tag;
                r_victim_data <= req_victim_data;
            end
            if ((r_state == S_FILL) && ready_MEM_L2) begin
                r_resp_data <= read_data_MEM_L2;
            end
            // Counter saturates; the error flag is sticky and never aborts the request.
            if (w_phase_entry) begin
                r_cnt <= '0;
            end else if (w_waiting) begin
                if (r_cnt != CNT_MAX) r_cnt <= r_cnt + 1'b1;
                if (r_cnt >= CNT_ARM) r_timeout_err <= 1'b1;
            end
        end
    end

    assign req_ready         = (r_state == S_IDLE) && rstn;
    assign resp_valid        = r_resp_valid;
    assign resp_data         = r_resp_data;
    assign read_L2_MEM       = r_read;
    assign write_L2_MEM      = r_write;
    assign tag_L2_MEM        = r_tag;
    assign index_L2_MEM      = r_index;
    assign write_tag_L2_MEM  = r_victim_tag;
    assign write_data_L2_MEM = r_victim_data;
    assign timeout_err       = r_timeout_err;

endmodule
